// File: rtl/rf_pkg.sv
// Shared definitions for the MIPS register file, its write-port arbiter and
// the decode-stage hazard logic.
//   REG_ADDR_W  : register address width
//   REG_DATA_W  : register data width
//   NUM_REGS    : number of architectural registers (r0 reads as zero)
//   arb_state_t : write-port arbiter state encoding
//   is_r0()     : true when an address names the hardwired-zero register
package rf_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FORCE = 2'd2
    } arb_state_t;

    function automatic logic is_r0(input logic [REG_ADDR_W-1:0] addr);
        return (addr == '0);
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-destination scoreboard for multi-cycle mul/div results.
// A register is marked busy when a mul/div op targeting it issues and is
// released when its result is accepted onto the write port. r0 is never busy.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   set_valid, set_addr  mul/div issue (marks destination busy)
//   clr_valid, clr_addr  mul/div result accepted (releases destination)
//   chk_addr1/2          lookup addresses from decode
//   chk_busy1/2          lookup results (combinational from state)
//   err                  protocol violation seen this cycle (double issue,
//                        or a result returning to a register not pending)
module rf_scoreboard
    import rf_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  set_valid,
    input  logic [REG_ADDR_W-1:0] set_addr,
    input  logic                  clr_valid,
    input  logic [REG_ADDR_W-1:0] clr_addr,
    input  logic [REG_ADDR_W-1:0] chk_addr1,
    input  logic [REG_ADDR_W-1:0] chk_addr2,
    output logic                  chk_busy1,
    output logic                  chk_busy2,
    output logic                  err
);

    // Only r1..r31 hold state; bit 0 of the full view is a constant zero.
    logic [NUM_REGS-1:1] busy_q;
    logic [NUM_REGS-1:1] busy_d;
    logic [NUM_REGS-1:0] busy_vec;
    logic                set_eff;
    logic                clr_eff;
    logic                clr_same;

    assign busy_vec = {busy_q, 1'b0};
    assign set_eff  = set_valid && !is_r0(set_addr);
    assign clr_eff  = clr_valid && !is_r0(clr_addr);
    assign clr_same = clr_eff && (clr_addr == set_addr);

    // Clear first, then set, so a same-cycle issue to a retiring register
    // leaves it busy for the newly issued op.
    always_comb begin
        busy_d = busy_q;
        if (clr_eff) begin
            busy_d[clr_addr] = 1'b0;
        end
        if (set_eff) begin
            busy_d[set_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign chk_busy1 = busy_vec[chk_addr1];
    assign chk_busy2 = busy_vec[chk_addr2];

    assign err = (set_eff && busy_vec[set_addr] && !clr_same)
               || (clr_eff && !busy_vec[clr_addr]);

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter with mul/div destination scoreboard.
// Shares the single write port between in-order writeback (A) and the
// mul/div result return (B). A normally wins; B is forced through after
// waiting STARVE_LIMIT cycles, with stall_req holding the pipeline off.
//
//   state | meaning
//   ------+---------------------------------------------
//   IDLE  | no B result waiting
//   WAIT  | B result waiting and losing to A
//   FORCE | B has priority, stall_req asserted
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   a_valid/a_addr/a_data       writeback request (always accepted)
//   b_valid/b_ready/b_addr/b_data  mul/div result handshake
//   iss_valid/iss_addr          mul/div issue, marks destination pending
//   chk_addr1/2, chk_busy1/2    decode RAW lookup
//   stall_req                   registered pipeline stall request
//   rf_wr_en/addr/data          registered register-file write port
//   proto_err                   sticky protocol-violation flag
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_valid,
    input  logic [REG_ADDR_W-1:0] a_addr,
    input  logic [REG_DATA_W-1:0] a_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [REG_ADDR_W-1:0] b_addr,
    input  logic [REG_DATA_W-1:0] b_data,
    input  logic                  iss_valid,
    input  logic [REG_ADDR_W-1:0] iss_addr,
    input  logic [REG_ADDR_W-1:0] chk_addr1,
    input  logic [REG_ADDR_W-1:0] chk_addr2,
    output logic                  chk_busy1,
    output logic                  chk_busy2,
    output logic                  stall_req,
    output logic                  rf_wr_en,
    output logic [REG_ADDR_W-1:0] rf_wr_addr,
    output logic [REG_DATA_W-1:0] rf_wr_data,
    output logic                  proto_err
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_FORCE = CNT_W'(STARVE_LIMIT - 1);

    arb_state_t     state;
    logic [CNT_W-1:0] wait_cnt;

    logic a_req;
    logic b_accept;
    logic b_denied;
    logic a_win;
    logic sb_err;

    // Writes to r0 are swallowed and never hold the port against B.
    assign a_req    = a_valid && !is_r0(a_addr);
    assign b_ready  = !a_req || (state == FORCE);
    assign b_accept = b_valid && b_ready;
    assign b_denied = b_valid && !b_ready;
    assign a_win    = a_req && !b_accept;

    rf_scoreboard u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_valid (iss_valid),
        .set_addr  (iss_addr),
        .clr_valid (b_accept),
        .clr_addr  (b_addr),
        .chk_addr1 (chk_addr1),
        .chk_addr2 (chk_addr2),
        .chk_busy1 (chk_busy1),
        .chk_busy2 (chk_busy2),
        .err       (sb_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            stall_req  <= 1'b0;
            rf_wr_en   <= 1'b0;
            rf_wr_addr <= '0;
            rf_wr_data <= '0;
            proto_err  <= 1'b0;
        end else begin
            rf_wr_en  <= 1'b0;
            stall_req <= 1'b0;

            if (b_accept) begin
                if (!is_r0(b_addr)) begin
                    rf_wr_en   <= 1'b1;
                    rf_wr_addr <= b_addr;
                    rf_wr_data <= b_data;
                end
            end else if (a_win) begin
                rf_wr_en   <= 1'b1;
                rf_wr_addr <= a_addr;
                rf_wr_data <= a_data;
            end

            if (!b_valid || b_accept) begin
                wait_cnt <= '0;
            end else if (wait_cnt != CNT_MAX) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            // wait_cnt is zero in IDLE, so the IDLE->FORCE shortcut only
            // fires for STARVE_LIMIT == 1 and keeps the wait bound at
            // STARVE_LIMIT+1 cycles there too.
            case (state)
                IDLE: begin
                    if (b_denied) begin
                        if (wait_cnt >= CNT_FORCE) begin
                            state     <= FORCE;
                            stall_req <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!b_valid || b_accept) begin
                        state <= IDLE;
                    end else if (wait_cnt >= CNT_FORCE) begin
                        state     <= FORCE;
                        stall_req <= 1'b1;
                    end
                end
                FORCE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if ((a_valid && stall_req) || sb_err) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic        iss_valid;
    logic [4:0]  iss_addr;
    logic [4:0]  chk_addr1;
    logic [4:0]  chk_addr2;
    logic        chk_busy1;
    logic        chk_busy2;
    logic        stall_req;
    logic        rf_wr_en;
    logic [4:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;
    logic        proto_err;

    int n_vec = 0;
    int n_err = 0;

    rf_wb_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a_valid    (a_valid),
        .a_addr     (a_addr),
        .a_data     (a_data),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .b_addr     (b_addr),
        .b_data     (b_data),
        .iss_valid  (iss_valid),
        .iss_addr   (iss_addr),
        .chk_addr1  (chk_addr1),
        .chk_addr2  (chk_addr2),
        .chk_busy1  (chk_busy1),
        .chk_busy2  (chk_busy2),
        .stall_req  (stall_req),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_addr (rf_wr_addr),
        .rf_wr_data (rf_wr_data),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_valid   = 1'b0;
        a_addr    = '0;
        a_data    = '0;
        b_valid   = 1'b0;
        b_addr    = '0;
        b_data    = '0;
        iss_valid = 1'b0;
        iss_addr  = '0;
    endtask

    task automatic issue(input logic [4:0] r);
        iss_valid = 1'b1;
        iss_addr  = r;
        step();
        iss_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        chk_addr1 = '0;
        chk_addr2 = '0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("rst_wr_en",   32'(rf_wr_en),   32'd0);
        check("rst_wr_addr", 32'(rf_wr_addr), 32'd0);
        check("rst_wr_data", rf_wr_data,      32'd0);
        check("rst_stall",   32'(stall_req),  32'd0);
        check("rst_proto",   32'(proto_err),  32'd0);
        check("rst_b_ready", 32'(b_ready),    32'd1);
        rst_n = 1'b1;
        step();

        // A write r5, then a write to r0
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
        step();
        check("a_wr_en",   32'(rf_wr_en),   32'd1);
        check("a_wr_addr", 32'(rf_wr_addr), 32'd5);
        check("a_wr_data", rf_wr_data,      32'hDEADBEEF);
        a_addr = 5'd0; a_data = 32'h11111111;
        #1;
        check("r0_b_ready", 32'(b_ready), 32'd1);
        step();
        check("r0_wr_en", 32'(rf_wr_en), 32'd0);
        idle_inputs();

        // Starvation: A holds r5, B returns r7
        issue(5'd7);
        chk_addr1 = 5'd7;
        #1;
        check("r7_busy_set", 32'(chk_busy1), 32'd1);
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hA5A5A5A5;
        b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h77770007;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("starve_b_ready_%0d", i), 32'(b_ready), 32'd0);
            check($sformatf("starve_stall_%0d", i), 32'(stall_req), 32'd0);
            step();
        end
        check("force_stall", 32'(stall_req), 32'd1);
        check("force_prev_a_addr", 32'(rf_wr_addr), 32'd5);
        a_valid = 1'b0;
        #1;
        check("force_b_ready", 32'(b_ready), 32'd1);
        step();
        b_valid = 1'b0;
        check("force_wr_en",   32'(rf_wr_en),   32'd1);
        check("force_wr_addr", 32'(rf_wr_addr), 32'd7);
        check("force_wr_data", rf_wr_data,      32'h77770007);
        check("force_stall_fall", 32'(stall_req), 32'd0);
        check("r7_busy_clr", 32'(chk_busy1), 32'd0);
        check("force_proto", 32'(proto_err), 32'd0);
        idle_inputs();

        // a_addr = 0 lets B through immediately
        issue(5'd9);
        chk_addr2 = 5'd9;
        a_valid = 1'b1; a_addr = 5'd0; a_data = 32'hFFFFFFFF;
        b_valid = 1'b1; b_addr = 5'd9; b_data = 32'h12345678;
        #1;
        check("r9_busy_pre",  32'(chk_busy2), 32'd1);
        check("r9_b_ready",   32'(b_ready),   32'd1);
        step();
        idle_inputs();
        check("r9_wr_en",   32'(rf_wr_en),   32'd1);
        check("r9_wr_addr", 32'(rf_wr_addr), 32'd9);
        check("r9_wr_data", rf_wr_data,      32'h12345678);
        check("r9_busy_clr", 32'(chk_busy2), 32'd0);

        // Scoreboard: r12 issue / return / simultaneous set+clear
        chk_addr1 = 5'd12;
        issue(5'd12);
        check("r12_busy_set", 32'(chk_busy1), 32'd1);
        b_valid = 1'b1; b_addr = 5'd12; b_data = 32'hCCCC000C;
        step();
        b_valid = 1'b0;
        check("r12_wr_en",    32'(rf_wr_en),   32'd1);
        check("r12_wr_addr",  32'(rf_wr_addr), 32'd12);
        check("r12_busy_clr", 32'(chk_busy1),  32'd0);
        issue(5'd12);
        iss_valid = 1'b1; iss_addr = 5'd12;
        b_valid = 1'b1; b_addr = 5'd12; b_data = 32'hCCCC0C0C;
        step();
        idle_inputs();
        check("r12_setclr_busy", 32'(chk_busy1), 32'd1);
        check("r12_setclr_wr",   rf_wr_data,     32'hCCCC0C0C);
        check("r12_setclr_proto", 32'(proto_err), 32'd0);
        b_valid = 1'b1; b_addr = 5'd12; b_data = 32'h0;
        step();
        idle_inputs();
        check("r12_final_clr", 32'(chk_busy1), 32'd0);
        check("r12_final_proto", 32'(proto_err), 32'd0);

        // Double issue to r3
        issue(5'd3);
        check("r3_single_proto", 32'(proto_err), 32'd0);
        issue(5'd3);
        check("r3_double_proto", 32'(proto_err), 32'd1);
        repeat (2) step();
        check("r3_proto_sticky", 32'(proto_err), 32'd1);
        rst_n = 1'b0;
        #1;
        check("r3_proto_rst", 32'(proto_err), 32'd0);
        #1;
        rst_n = 1'b1;
        step();

        // a_valid held during stall: B wins, A dropped, proto_err set
        chk_addr1 = 5'd4;
        issue(5'd4);
        a_valid = 1'b1; a_addr = 5'd6; a_data = 32'h66666666;
        b_valid = 1'b1; b_addr = 5'd4; b_data = 32'h44440004;
        repeat (4) step();
        check("stall_a_stall", 32'(stall_req), 32'd1);
        step();
        check("stall_a_proto",   32'(proto_err),  32'd1);
        check("stall_a_wr_addr", 32'(rf_wr_addr), 32'd4);
        check("stall_a_wr_data", rf_wr_data,      32'h44440004);
        check("stall_a_busy4",   32'(chk_busy1),  32'd0);
        idle_inputs();
        step();

        // Reset while in FORCE with r4 pending
        issue(5'd4);
        a_valid = 1'b1; a_addr = 5'd6; a_data = 32'h66666666;
        b_valid = 1'b1; b_addr = 5'd4; b_data = 32'h44444444;
        repeat (4) step();
        check("rstf_stall_pre", 32'(stall_req), 32'd1);
        check("rstf_busy_pre",  32'(chk_busy1), 32'd1);
        check("rstf_wr_en_pre", 32'(rf_wr_en),  32'd1);
        rst_n = 1'b0;
        idle_inputs();
        #1;
        check("rstf_wr_en",   32'(rf_wr_en),   32'd0);
        check("rstf_wr_addr", 32'(rf_wr_addr), 32'd0);
        check("rstf_wr_data", rf_wr_data,      32'd0);
        check("rstf_stall",   32'(stall_req),  32'd0);
        check("rstf_proto",   32'(proto_err),  32'd0);
        check("rstf_busy",    32'(chk_busy1),  32'd0);
        check("rstf_b_ready", 32'(b_ready),    32'd1);
        #1;
        rst_n = 1'b1;
        step();
        check("rstf_post_wr_en0", 32'(rf_wr_en), 32'd0);
        step();
        check("rstf_post_wr_en1", 32'(rf_wr_en), 32'd0);
        check("rstf_post_stall",  32'(stall_req), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-port arbiter and destination scoreboard for the 32×32 MIPS register file. It shares the file's single write port between the in-order pipeline writeback (port A) and the multi-cycle mul/div result return (port B), with a starvation guard for B. It tracks mul/div destinations that are still pending so the decode stage can stall on RAW hazards. It sits between the writeback stage, the mul/div unit and the register file's write inputs.

## Interface
- STARVE_LIMIT, 4: consecutive cycles B may wait before a forced grant (≥1)
- clk  in  1  clock; all state on posedge
- rst_n  in  1  asynchronous active-low reset
- a_valid  in  1  pipeline writeback request; no ready, always accepted unless overridden
- a_addr  in  5  pipeline destination register
- a_data  in  32  pipeline write data
- b_valid  in  1  mul/div result valid; held with addr/data stable until b_ready
- b_ready  out  1  B accepted this cycle when b_valid && b_ready
- b_addr  in  5  mul/div destination register
- b_data  in  32  mul/div result
- iss_valid  in  1  mul/div op issued this cycle
- iss_addr  in  5  destination of the issued op
- chk_addr1, chk_addr2  in  5  decode source registers
- chk_busy1, chk_busy2  out  1  source has a pending mul/div write (combinational from scoreboard)
- stall_req  out  1  registered; pipeline must hold a_valid low next cycle
- rf_wr_en  out  1  register-file write enable
- rf_wr_addr  out  5  register-file write address
- rf_wr_data  out  32  register-file write data
- proto_err  out  1  sticky protocol-violation flag

## Operation
- Effective A request: a_req = a_valid && a_addr != 0. Writes to r0 are accepted and discarded, and they do not occupy the port.
- FSM states:
  - IDLE: no B waiting.
  - WAIT: B waiting and losing.
  - FORCE: stall_req = 1, B has priority.
- b_ready = !a_req || state == FORCE.
- Winner each cycle:
  - FORCE with b_valid: B wins.
  - Otherwise with a_req: A wins.
  - Otherwise with b_valid: B wins.
  - Otherwise: no write.
- A B-grant with b_addr == 0 completes the handshake and produces no write.
- wait_cnt counts cycles with b_valid && !b_ready. It resets to 0 on any B accept or when b_valid is low.
- FSM transitions:
  - IDLE→WAIT when B is denied.
  - WAIT→FORCE when wait_cnt reaches STARVE_LIMIT−1 with B still denied.
  - WAIT→IDLE on B accept.
  - FORCE→IDLE on B accept. B is always accepted in FORCE if b_valid.
  - FORCE→IDLE if b_valid drops.
- Scoreboard busy[31:1], busy[0] hardwired 0:
  - Set on iss_valid at iss_addr.
  - Cleared on B accept at b_addr.
  - Set and clear of the same register in the same cycle: set wins.
  - chk_busyN = busy[chk_addrN].
- proto_err is set and held until reset on any of:
  - a_valid while stall_req = 1. B still wins and the A write is dropped.
  - iss_valid to a register already busy and not clearing this cycle.
  - B accept to a register that is not busy.
- Width rules: no arithmetic on data. wait_cnt width is $clog2(STARVE_LIMIT+1) and saturates.

## Timing
- Reset values: state IDLE, wait_cnt 0, busy all 0, rf_wr_en 0, rf_wr_addr 0, rf_wr_data 0, stall_req 0, proto_err 0. b_ready resets to 1 (combinational, given no a_req).
- Write latency is 1. The winner in cycle N drives rf_wr_* registered in cycle N+1. The register file commits on the negedge inside N+1.
- The scoreboard clear from a B accept in cycle N is visible in N+1, aligned with rf_wr_en. A read latched at the end of N+1 sees the new value.
- stall_req is registered. It rises the cycle after the WAIT→FORCE decision and falls the cycle after the forced accept. The maximum B wait is STARVE_LIMIT+1 cycles.
- Reset asserted mid-transaction aborts it. The pending write is lost, busy is cleared, and no write is issued after reset release until a new request arrives.

## Structure
- Shared package rf_pkg holds REG_ADDR_W=5, REG_DATA_W=32, the arb_state_t enum (IDLE, WAIT, FORCE) and NUM_REGS=32. The package is shared with the register file and the decode hazard logic.
- One sub-module, rf_scoreboard. It owns busy[], the set/clear/priority logic, the two lookup ports and the busy-related proto_err terms.

## Test plan
- Reset, then A writes r5 = 0xDEADBEEF → the next cycle shows rf_wr_en = 1, addr 5, data 0xDEADBEEF. A write to r0 gives rf_wr_en = 0.
- A and B (r7) valid together, STARVE_LIMIT = 4, A held continuously → b_ready is low for 4 cycles, stall_req rises, B is accepted, and a write to r7 follows one cycle later. Max wait is 5 cycles.
- a_addr = 0 while b_valid (r9 = 0x12345678) → B is accepted in the same cycle, and r9 is written the next cycle.
- Issue r12, then check chk_addr1 = 12 → busy = 1. B returns r12 → busy = 0 in the cycle rf_wr_en = 1. Issue r12 and accept B r12 in the same cycle → busy stays 1.
- a_valid asserted during stall_req, or a double issue to r3 → proto_err = 1 and it stays set until rst_n.
- rst_n pulsed low while in FORCE with busy[4] = 1 → all outputs return to reset values immediately, and no stale write appears after release.
